// File: rtl/uc_pkg.sv
// Shared encodings for the microc sequencer: FSM states, opcode classes,
// ALU operation codes and the packed control word driven to the datapath.
package uc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  // Opcode[5:2] class prefixes; ALU instructions are any opcode with Opcode[5] = 0
  localparam logic       CLS_ALU     = 1'b0;
  localparam logic [3:0] CLS_LI      = 4'b1000;
  localparam logic [3:0] CLS_J       = 4'b1001;
  localparam logic [3:0] CLS_JZ      = 4'b1010;
  localparam logic [3:0] CLS_JNZ     = 4'b1011;
  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] op;
    logic       pc_en;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0,
                                  wez: 1'b0, op: OP_NONE, pc_en: 1'b0};

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode/z decode into the datapath control word.
module uc_decode
  import uc_pkg::*;
#(
  parameter logic [5:0] HALT_OP = HALT_OPCODE
) (
  input  logic [5:0] opcode,
  input  logic       z,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl       = CTRL_IDLE;
    ctrl.pc_en = 1'b1;
    if (opcode == HALT_OP) begin
      ctrl.pc_en = 1'b0;
    end else if (opcode[5] == CLS_ALU) begin
      ctrl.we3 = 1'b1;
      ctrl.wez = 1'b1;
      ctrl.op  = opcode[4:2];
    end else begin
      case (opcode[5:2])
        CLS_LI: begin
          ctrl.s_inm = 1'b1;
          ctrl.we3   = 1'b1;
        end
        CLS_J:   ctrl.s_inc = 1'b0;
        CLS_JZ:  ctrl.s_inc = ~z;
        CLS_JNZ: ctrl.s_inc = z;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uc_seq.sv
// Sequential control unit for microc: run/step/halt FSM around uc_decode,
// with step-edge detection and a saturating retired-instruction counter.
module uc_seq
  import uc_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
  input  logic             run_en,
  input  logic             step_req,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t state, state_nxt;
  logic   step_prev;
  logic   step_edge;
  logic   is_halt;
  logic   exec;
  ctrl_t  dec;
  ctrl_t  ctrl;

  uc_decode #(.HALT_OP(HALT_OP)) u_decode (
    .opcode (Opcode),
    .z      (z),
    .ctrl   (dec)
  );

  assign step_edge = step_req & ~step_prev;
  assign is_halt   = (Opcode == HALT_OP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      step_prev <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state     <= state_nxt;
      step_prev <= step_req;
      if (exec && !is_halt && (instr_cnt != '1))
        instr_cnt <= instr_cnt + 1'b1;
    end
  end

  // Reset gates exec and halted so the reset cycle itself drives the idle word
  always_comb begin
    state_nxt = state;
    exec      = 1'b0;
    halted    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run_en)         state_nxt = ST_RUN;
        else if (step_edge) state_nxt = ST_STEP;
      end
      ST_RUN: begin
        exec = 1'b1;
        if (is_halt)        state_nxt = ST_HALT;
        else if (!run_en)   state_nxt = ST_IDLE;
      end
      ST_STEP: begin
        exec      = 1'b1;
        state_nxt = is_halt ? ST_HALT : ST_IDLE;
      end
      ST_HALT: halted = 1'b1;
      default: state_nxt = ST_IDLE;
    endcase
    if (reset) begin
      exec   = 1'b0;
      halted = 1'b0;
    end
  end

  assign ctrl  = exec ? dec : CTRL_IDLE;
  assign s_inc = ctrl.s_inc;
  assign s_inm = ctrl.s_inm;
  assign we3   = ctrl.we3;
  assign wez   = ctrl.wez;
  assign Op    = ctrl.op;
  assign pc_en = ctrl.pc_en;

endmodule

// File: tb/tb_uc_seq.sv
// Bench for uc_seq: per-cycle vector table through a scoreboard queue,
// plus a saturation sequence on a narrow-counter instance.
module tb_uc_seq;

  typedef struct {
    logic        rst;
    logic        run;
    logic        step;
    logic [5:0]  op;
    logic        z;
    logic [7:0]  ctrl;    // {s_inc, s_inm, we3, wez, Op[2:0], pc_en}
    logic        halted;
    logic [15:0] cnt;
  } vec_t;

  localparam logic [7:0] W_OFF  = 8'b1000_0000;
  localparam logic [7:0] W_A001 = 8'b1011_0011;
  localparam logic [7:0] W_A011 = 8'b1011_0111;
  localparam logic [7:0] W_A100 = 8'b1011_1001;
  localparam logic [7:0] W_LI   = 8'b1110_0001;
  localparam logic [7:0] W_JMP  = 8'b0000_0001;
  localparam logic [7:0] W_SEQ  = 8'b1000_0001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  Opcode = 6'b000100;
  logic        z = 1'b0;
  logic        run_en = 1'b0;
  logic        step_req = 1'b0;

  logic        s_inc, s_inm, we3, wez, pc_en, halted;
  logic [2:0]  Op;
  logic [15:0] instr_cnt;
  logic        s_inc4, s_inm4, we34, wez4, pc_en4, halted4;
  logic [2:0]  Op4;
  logic [3:0]  instr_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vt[$];
  vec_t exp_q[$];
  int   sat_q[$];

  always #5 clk = ~clk;

  uc_seq #(.CNT_W(16), .HALT_OP(6'b111111)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .run_en(run_en),
    .step_req(step_req), .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez),
    .Op(Op), .pc_en(pc_en), .halted(halted), .instr_cnt(instr_cnt)
  );

  uc_seq #(.CNT_W(4), .HALT_OP(6'b111111)) dut4 (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .run_en(run_en),
    .step_req(step_req), .s_inc(s_inc4), .s_inm(s_inm4), .we3(we34), .wez(wez4),
    .Op(Op4), .pc_en(pc_en4), .halted(halted4), .instr_cnt(instr_cnt4)
  );

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic row(input logic rst, input logic run, input logic step,
                     input logic [5:0] op, input logic zz, input logic [7:0] w,
                     input logic h, input logic [15:0] c);
    vec_t v;
    v.rst = rst; v.run = run; v.step = step; v.op = op; v.z = zz;
    v.ctrl = w; v.halted = h; v.cnt = c;
    vt.push_back(v);
  endtask

  initial begin
    vec_t e;
    // reset hold with run_en high, then first RUN cycle
    row(1, 1, 0, 6'b000100, 0, W_OFF,  0, 0);
    row(1, 1, 0, 6'b000100, 0, W_OFF,  0, 0);
    row(0, 1, 0, 6'b000100, 0, W_OFF,  0, 0);
    row(0, 1, 0, 6'b000100, 0, W_A001, 0, 0);
    // reset mid-RUN, then LI / SUB / JZ / JNZ / J / NOP
    row(1, 1, 0, 6'b000100, 0, W_OFF,  0, 1);
    row(0, 1, 0, 6'b100000, 0, W_OFF,  0, 0);
    row(0, 1, 0, 6'b100000, 0, W_LI,   0, 0);
    row(0, 1, 0, 6'b001100, 0, W_A011, 0, 1);
    row(0, 1, 0, 6'b101000, 1, W_JMP,  0, 2);
    row(0, 1, 0, 6'b101100, 0, W_JMP,  0, 3);
    row(0, 1, 0, 6'b101100, 1, W_SEQ,  0, 4);
    row(0, 1, 0, 6'b101000, 0, W_SEQ,  0, 5);
    row(0, 1, 0, 6'b100100, 1, W_JMP,  0, 6);
    row(0, 1, 0, 6'b110000, 0, W_SEQ,  0, 7);
    row(0, 0, 0, 6'b000100, 0, W_A001, 0, 8);
    // step held 5 cycles -> one instruction; second edge -> one more
    row(0, 0, 1, 6'b010000, 0, W_OFF,  0, 9);
    row(0, 0, 1, 6'b010000, 0, W_A100, 0, 9);
    row(0, 0, 1, 6'b010000, 0, W_OFF,  0, 10);
    row(0, 0, 1, 6'b010000, 0, W_OFF,  0, 10);
    row(0, 0, 1, 6'b010000, 0, W_OFF,  0, 10);
    row(0, 0, 0, 6'b010000, 0, W_OFF,  0, 10);
    row(0, 0, 1, 6'b010000, 0, W_OFF,  0, 10);
    row(0, 0, 1, 6'b010000, 0, W_A100, 0, 10);
    row(0, 0, 0, 6'b010000, 0, W_OFF,  0, 11);
    // halt in RUN, sticky against run_en/step, cleared by reset
    row(0, 1, 0, 6'b111111, 0, W_OFF,  0, 11);
    row(0, 1, 0, 6'b111111, 0, W_OFF,  0, 11);
    row(0, 1, 1, 6'b000100, 0, W_OFF,  1, 11);
    row(0, 1, 0, 6'b000100, 0, W_OFF,  1, 11);
    row(0, 1, 1, 6'b000100, 0, W_OFF,  1, 11);
    row(1, 0, 0, 6'b000100, 0, W_OFF,  0, 11);
    row(0, 0, 0, 6'b000100, 0, W_OFF,  0, 0);

    @(posedge clk);
    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk);
      #1;
      reset = vt[i].rst; run_en = vt[i].run; step_req = vt[i].step;
      Opcode = vt[i].op; z = vt[i].z;
      exp_q.push_back(vt[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      check("ctrl", i, {24'd0, s_inc, s_inm, we3, wez, Op, pc_en}, {24'd0, e.ctrl});
      check("halted", i, {31'd0, halted}, {31'd0, e.halted});
      check("instr_cnt", i, {16'd0, instr_cnt}, {16'd0, e.cnt});
    end

    // 4-bit counter saturates at 15 while instructions keep executing
    @(posedge clk); #1;
    reset = 1'b1; run_en = 1'b1; step_req = 1'b0; Opcode = 6'b000100;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k <= 20; k++) begin
      sat_q.push_back((k > 15) ? 15 : k);
      sat_q.push_back(k);
      @(negedge clk);
      check("cnt4_sat", k, {28'd0, instr_cnt4}, sat_q.pop_front());
      check("cnt16", k, {16'd0, instr_cnt}, sat_q.pop_front());
      check("we3_sat", k, {31'd0, we34}, 32'd1);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
